// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_channel slice (state encoding, parity modes,
// oversampling ratio, rx word status-bit offsets and the baud divisor calculation).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  localparam int OVERSAMPLE = 16;

  // Status flags counted down from the top bit of the rx word.
  localparam int RX_PERR_BIT = 1;
  localparam int RX_FERR_BIT = 2;

  function automatic int calc_div(input int clockFreq, input int baudRate);
    int d;
    d = clockFreq / (baudRate * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic logic parity_bit(input parity_e mode, input logic dataXor);
    return (mode == PAR_ODD) ? ~dataXor : dataXor;
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running divisor counter producing the 16x-oversampling clock enable (tick16)
// shared by the TX and RX state machines.
module uart_tick_gen
  import uart_pkg::*;
#(
  parameter int clock_freq = 10000000,
  parameter int baud_rate  = 9600
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick16
);

  localparam int DIV = calc_div(clock_freq, baud_rate);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_tick16 = (r_count == LAST);

endmodule

// File: rtl/uart_channel.sv
// Parametrised UART between the USB packet FIFOs and the external pins: TX pops the tx FIFO,
// RX pushes char+status into the rx FIFO. Optional RTS/CTS flow control under UART_RTS_CTS_EN.
module uart_channel
  import uart_pkg::*;
#(
  parameter int    baud_rate        = 9600,
  parameter int    clock_freq       = 10000000,
  parameter string parity           = "none",
  parameter int    data_bits        = 8,
  parameter int    stop_bits        = 1,
  parameter int    usb_packet_width = 32
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef UART_RTS_CTS_EN
  input  logic                        cts_n,
  output logic                        rts_n,
`endif
  input  logic                        rx,
  output logic                        tx,
  input  logic [usb_packet_width-1:0] tx_data,
  input  logic                        tx_empty,
  output logic                        tx_rden,
  output logic                        tx_busy,
  output logic [usb_packet_width-1:0] rx_data,
  input  logic                        rx_full,
  output logic                        rx_wren,
  output logic                        rx_overrun
);

  localparam parity_e PAR_MODE = (parity == "even") ? PAR_EVEN :
                                 (parity == "odd")  ? PAR_ODD  : PAR_NONE;
  localparam logic [3:0] LAST_BIT  = 4'(data_bits - 1);
  localparam logic [3:0] LAST_STOP = 4'(stop_bits - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);

  logic w_tick16;

  uart_tick_gen #(
    .clock_freq(clock_freq),
    .baud_rate (baud_rate)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .o_tick16(w_tick16)
  );

  logic w_unusedTxData;
  assign w_unusedTxData = ^tx_data[usb_packet_width-1:data_bits];

  logic w_txAllowed;
`ifdef UART_RTS_CTS_EN
  logic [1:0] r_ctsSync;
  logic       r_rts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctsSync <= 2'b11;
      r_rts     <= 1'b1;
    end else begin
      r_ctsSync <= {r_ctsSync[0], cts_n};
      r_rts     <= rx_full;
    end
  end

  assign w_txAllowed = ~r_ctsSync[1];
  assign rts_n       = r_rts;
`else
  assign w_txAllowed = 1'b1;
`endif

  uart_state_e          r_txState, w_txState_n;
  logic [3:0]           r_txTick, w_txTick_n;
  logic [3:0]           r_txBit, w_txBit_n;
  logic [data_bits-1:0] r_txShift, w_txShift_n;
  logic                 r_txPar, w_txPar_n;
  logic                 r_tx, w_txLine_n;
  logic                 w_txEnd, w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txState <= IDLE;
      r_txTick  <= '0;
      r_txBit   <= '0;
      r_txShift <= '0;
      r_txPar   <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_txState <= w_txState_n;
      r_txTick  <= w_txTick_n;
      r_txBit   <= w_txBit_n;
      r_txShift <= w_txShift_n;
      r_txPar   <= w_txPar_n;
      r_tx      <= w_txLine_n;
    end
  end

  // The line level is registered from the next state so tx never glitches between bits.
  always_comb begin
    w_txState_n = r_txState;
    w_txTick_n  = r_txTick;
    w_txBit_n   = r_txBit;
    w_txShift_n = r_txShift;
    w_txPar_n   = r_txPar;
    w_pop       = 1'b0;
    w_txEnd     = w_tick16 && (r_txTick == LAST_TICK);
    if (w_tick16 && (r_txState != IDLE)) begin
      w_txTick_n = r_txTick + 4'd1;
    end
    case (r_txState)
      IDLE: begin
        if (!tx_empty && w_txAllowed) begin
          w_pop       = 1'b1;
          w_txShift_n = tx_data[data_bits-1:0];
          w_txPar_n   = parity_bit(PAR_MODE, ^tx_data[data_bits-1:0]);
          w_txTick_n  = '0;
          w_txBit_n   = '0;
          w_txState_n = START;
        end
      end
      START: if (w_txEnd) w_txState_n = DATA;
      DATA: begin
        if (w_txEnd) begin
          w_txShift_n = r_txShift >> 1;
          if (r_txBit == LAST_BIT) begin
            w_txBit_n   = '0;
            w_txState_n = (PAR_MODE == PAR_NONE) ? STOP : PARITY;
          end else begin
            w_txBit_n = r_txBit + 4'd1;
          end
        end
      end
      PARITY: if (w_txEnd) w_txState_n = STOP;
      STOP: begin
        if (w_txEnd) begin
          if (r_txBit == LAST_STOP) begin
            w_txState_n = IDLE;
          end else begin
            w_txBit_n = r_txBit + 4'd1;
          end
        end
      end
      default: w_txState_n = IDLE;
    endcase
    case (w_txState_n)
      START:   w_txLine_n = 1'b0;
      DATA:    w_txLine_n = w_txShift_n[0];
      PARITY:  w_txLine_n = w_txPar_n;
      default: w_txLine_n = 1'b1;
    endcase
  end

  assign tx      = r_tx;
  assign tx_busy = (r_txState != IDLE);
  assign tx_rden = w_pop & ~rst;

  logic [1:0]                  r_rxSync;
  logic                        r_rxPrev;
  uart_state_e                 r_rxState, w_rxState_n;
  logic [3:0]                  r_rxTick, w_rxTick_n;
  logic [3:0]                  r_rxBit, w_rxBit_n;
  logic [data_bits-1:0]        r_rxShift, w_rxShift_n;
  logic                        r_rxPerr, w_rxPerr_n;
  logic [usb_packet_width-1:0] r_rxData, w_rxWord;
  logic                        r_rxWren, r_rxOverrun;
  logic                        w_rxIn, w_rxFall, w_rxSample, w_rxDone;

  assign w_rxIn   = r_rxSync[1];
  assign w_rxFall = r_rxPrev & ~w_rxIn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxSync    <= 2'b11;
      r_rxPrev    <= 1'b1;
      r_rxState   <= IDLE;
      r_rxTick    <= '0;
      r_rxBit     <= '0;
      r_rxShift   <= '0;
      r_rxPerr    <= 1'b0;
      r_rxData    <= '0;
      r_rxWren    <= 1'b0;
      r_rxOverrun <= 1'b0;
    end else begin
      r_rxSync  <= {r_rxSync[0], rx};
      r_rxPrev  <= w_rxIn;
      r_rxState <= w_rxState_n;
      r_rxTick  <= w_rxTick_n;
      r_rxBit   <= w_rxBit_n;
      r_rxShift <= w_rxShift_n;
      r_rxPerr  <= w_rxPerr_n;
      r_rxWren  <= 1'b0;
      if (w_rxDone) begin
        if (rx_full) begin
          r_rxOverrun <= 1'b1;
        end else begin
          r_rxWren <= 1'b1;
          r_rxData <= w_rxWord;
        end
      end
    end
  end

  // START samples half a bit in; every later sample lands 16 ticks on, i.e. mid-bit.
  always_comb begin
    w_rxState_n = r_rxState;
    w_rxTick_n  = r_rxTick;
    w_rxBit_n   = r_rxBit;
    w_rxShift_n = r_rxShift;
    w_rxPerr_n  = r_rxPerr;
    w_rxDone    = 1'b0;
    w_rxSample  = w_tick16 &&
                  (r_rxTick == ((r_rxState == START) ? MID_TICK : LAST_TICK));
    if (w_tick16 && (r_rxState != IDLE)) begin
      w_rxTick_n = r_rxTick + 4'd1;
    end
    case (r_rxState)
      IDLE: begin
        if (w_rxFall) begin
          w_rxState_n = START;
          w_rxTick_n  = '0;
          w_rxBit_n   = '0;
          w_rxPerr_n  = 1'b0;
        end
      end
      START: begin
        if (w_rxSample) begin
          w_rxTick_n  = '0;
          w_rxState_n = w_rxIn ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_rxSample) begin
          w_rxShift_n = {w_rxIn, r_rxShift[data_bits-1:1]};
          if (r_rxBit == LAST_BIT) begin
            w_rxBit_n   = '0;
            w_rxState_n = (PAR_MODE == PAR_NONE) ? STOP : PARITY;
          end else begin
            w_rxBit_n = r_rxBit + 4'd1;
          end
        end
      end
      PARITY: begin
        if (w_rxSample) begin
          w_rxPerr_n  = w_rxIn ^ parity_bit(PAR_MODE, ^r_rxShift);
          w_rxState_n = STOP;
        end
      end
      STOP: begin
        if (w_rxSample) begin
          w_rxDone    = 1'b1;
          w_rxState_n = IDLE;
        end
      end
      default: w_rxState_n = IDLE;
    endcase
    w_rxWord                                   = '0;
    w_rxWord[data_bits-1:0]                    = r_rxShift;
    w_rxWord[usb_packet_width-RX_PERR_BIT]     = r_rxPerr;
    w_rxWord[usb_packet_width-RX_FERR_BIT]     = ~w_rxIn;
  end

  assign rx_data    = r_rxData;
  assign rx_wren    = r_rxWren;
  assign rx_overrun = r_rxOverrun;

endmodule

// File: tb/tb_uart_channel.sv
// Directed bench for uart_channel: an 8N1 instance for TX and a 7E2 instance for RX,
// both at 16 clk per bit. RTS/CTS checks are included when UART_RTS_CTS_EN is defined.
module tb_uart_channel;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rx8, tx8, txEmpty8, txRden8, txBusy8, rxFull8, unusedRxWren8, unusedRxOverrun8;
  logic [31:0] txData8, unusedRxData8;
  logic        rx7, unusedTx7, txEmpty7, unusedTxRden7, unusedTxBusy7, rxFull7, rxWren7, rxOverrun7;
  logic [31:0] txData7, rxData7;
`ifdef UART_RTS_CTS_EN
  logic cts8, unusedRts8, cts7, rts7;
`endif

  int passCount  = 0;
  int checkCount = 0;
  int popCount8  = 0;
  int wrenCount7 = 0;
  logic [31:0] capData7 = '0;

  uart_channel #(
    .baud_rate(115200), .clock_freq(1843200), .parity("none"),
    .data_bits(8), .stop_bits(1), .usb_packet_width(32)
  ) u8n1 (
    .clk(clk), .rst(rst),
`ifdef UART_RTS_CTS_EN
    .cts_n(cts8), .rts_n(unusedRts8),
`endif
    .rx(rx8), .tx(tx8), .tx_data(txData8), .tx_empty(txEmpty8),
    .tx_rden(txRden8), .tx_busy(txBusy8), .rx_data(unusedRxData8),
    .rx_full(rxFull8), .rx_wren(unusedRxWren8), .rx_overrun(unusedRxOverrun8)
  );

  uart_channel #(
    .baud_rate(115200), .clock_freq(1843200), .parity("even"),
    .data_bits(7), .stop_bits(2), .usb_packet_width(32)
  ) u7e2 (
    .clk(clk), .rst(rst),
`ifdef UART_RTS_CTS_EN
    .cts_n(cts7), .rts_n(rts7),
`endif
    .rx(rx7), .tx(unusedTx7), .tx_data(txData7), .tx_empty(txEmpty7),
    .tx_rden(unusedTxRden7), .tx_busy(unusedTxBusy7), .rx_data(rxData7),
    .rx_full(rxFull7), .rx_wren(rxWren7), .rx_overrun(rxOverrun7)
  );

  always @(negedge clk) begin
    if (txRden8) popCount8++;
    if (rxWren7) begin
      wrenCount7++;
      capData7 = rxData7;
    end
  end

  task automatic driveBit7(input logic b);
    @(posedge clk);
    #2;
    rx7 = b;
    repeat (15) @(posedge clk);
  endtask

  task automatic sendFrame7(input logic [6:0] ch, input logic parFlip, input logic stopLow);
    driveBit7(1'b0);
    for (int i = 0; i < 7; i++) driveBit7(ch[i]);
    driveBit7((^ch) ^ parFlip);
    driveBit7(~stopLow);
    driveBit7(1'b1);
    driveBit7(1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx8 = 1'b1; rx7 = 1'b1;
    txEmpty8 = 1'b1; txEmpty7 = 1'b1;
    txData8 = '0; txData7 = '0;
    rxFull8 = 1'b0; rxFull7 = 1'b0;
`ifdef UART_RTS_CTS_EN
    cts8 = 1'b0; cts7 = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checkCount++; if (tx8 !== 1'b1) $display("[TB] FAIL reset_tx actual=%b expected=1", tx8); else passCount++;
    checkCount++; if (txBusy8 !== 1'b0) $display("[TB] FAIL reset_busy actual=%b expected=0", txBusy8); else passCount++;
    checkCount++; if (txRden8 !== 1'b0) $display("[TB] FAIL reset_rden actual=%b expected=0", txRden8); else passCount++;
    checkCount++; if (rxWren7 !== 1'b0) $display("[TB] FAIL reset_wren actual=%b expected=0", rxWren7); else passCount++;
    checkCount++; if (rxOverrun7 !== 1'b0) $display("[TB] FAIL reset_overrun actual=%b expected=0", rxOverrun7); else passCount++;
    checkCount++; if (rxData7 !== 32'h0) $display("[TB] FAIL reset_rxdata actual=%h expected=00000000", rxData7); else passCount++;
`ifdef UART_RTS_CTS_EN
    checkCount++; if (rts7 !== 1'b1) $display("[TB] FAIL reset_rts actual=%b expected=1", rts7); else passCount++;
`endif
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_tx_8n1();
    logic expWave [10];
    logic obsWave [10];
    logic badBusy;
    int   pops0;
    expWave = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    obsWave = expWave;
    badBusy = 1'b0;
    @(posedge clk);
    #2;
    pops0    = popCount8;
    txData8  = 32'h000000A5;
    txEmpty8 = 1'b0;
    #1;
    checkCount++; if (txRden8 !== 1'b1) $display("[TB] FAIL tx_pop actual=%b expected=1", txRden8); else passCount++;
    @(posedge clk);
    #1;
    txEmpty8 = 1'b1;
    for (int k = 0; k < 160; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (tx8 !== expWave[k/16]) obsWave[k/16] = tx8;
      if (txBusy8 !== 1'b1) badBusy = 1'b1;
    end
    for (int b = 0; b < 10; b++) begin
      checkCount++;
      if (obsWave[b] !== expWave[b]) $display("[TB] FAIL tx_bit%0d actual=%b expected=%b", b, obsWave[b], expWave[b]);
      else passCount++;
    end
    checkCount++; if (badBusy !== 1'b0) $display("[TB] FAIL tx_busy_frame actual=dropped expected=high 160 clk"); else passCount++;
    @(posedge clk);
    #1;
    checkCount++; if (txBusy8 !== 1'b0) $display("[TB] FAIL tx_busy_end actual=%b expected=0", txBusy8); else passCount++;
    checkCount++; if (tx8 !== 1'b1) $display("[TB] FAIL tx_idle actual=%b expected=1", tx8); else passCount++;
    checkCount++; if (popCount8 - pops0 !== 1) $display("[TB] FAIL tx_pop_count actual=%0d expected=1", popCount8 - pops0); else passCount++;
  endtask

  task automatic test_rx_frames();
    int w0;
    w0 = wrenCount7;
    sendFrame7(7'h41, 1'b0, 1'b0);
    checkCount++; if (wrenCount7 - w0 !== 1) $display("[TB] FAIL rx_good_wren actual=%0d expected=1", wrenCount7 - w0); else passCount++;
    checkCount++; if (capData7 !== 32'h00000041) $display("[TB] FAIL rx_good_data actual=%h expected=00000041", capData7); else passCount++;
    w0 = wrenCount7;
    sendFrame7(7'h41, 1'b1, 1'b0);
    checkCount++; if (wrenCount7 - w0 !== 1) $display("[TB] FAIL rx_perr_wren actual=%0d expected=1", wrenCount7 - w0); else passCount++;
    checkCount++; if (capData7 !== 32'h80000041) $display("[TB] FAIL rx_perr_data actual=%h expected=80000041", capData7); else passCount++;
    w0 = wrenCount7;
    sendFrame7(7'h41, 1'b0, 1'b1);
    checkCount++; if (wrenCount7 - w0 !== 1) $display("[TB] FAIL rx_ferr_wren actual=%0d expected=1", wrenCount7 - w0); else passCount++;
    checkCount++; if (capData7 !== 32'h40000041) $display("[TB] FAIL rx_ferr_data actual=%h expected=40000041", capData7); else passCount++;
  endtask

  task automatic test_glitch();
    int w0;
    w0 = wrenCount7;
    @(posedge clk);
    #2;
    rx7 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rx7 = 1'b1;
    repeat (40) @(posedge clk);
    checkCount++; if (wrenCount7 - w0 !== 0) $display("[TB] FAIL glitch_wren actual=%0d expected=0", wrenCount7 - w0); else passCount++;
    sendFrame7(7'h2C, 1'b0, 1'b0);
    checkCount++; if (wrenCount7 - w0 !== 1) $display("[TB] FAIL glitch_next_wren actual=%0d expected=1", wrenCount7 - w0); else passCount++;
    checkCount++; if (capData7 !== 32'h0000002C) $display("[TB] FAIL glitch_next_data actual=%h expected=0000002c", capData7); else passCount++;
  endtask

  task automatic test_overrun();
    int w0;
    w0 = wrenCount7;
    @(posedge clk);
    #2;
    rxFull7 = 1'b1;
    sendFrame7(7'h55, 1'b0, 1'b0);
    checkCount++; if (wrenCount7 - w0 !== 0) $display("[TB] FAIL ovr_wren actual=%0d expected=0", wrenCount7 - w0); else passCount++;
    checkCount++; if (rxOverrun7 !== 1'b1) $display("[TB] FAIL ovr_flag actual=%b expected=1", rxOverrun7); else passCount++;
    checkCount++; if (rxData7 !== 32'h0000002C) $display("[TB] FAIL ovr_hold actual=%h expected=0000002c", rxData7); else passCount++;
    rxFull7 = 1'b0;
    sendFrame7(7'h12, 1'b0, 1'b0);
    checkCount++; if (capData7 !== 32'h00000012) $display("[TB] FAIL ovr_next_data actual=%h expected=00000012", capData7); else passCount++;
    checkCount++; if (rxOverrun7 !== 1'b1) $display("[TB] FAIL ovr_sticky actual=%b expected=1", rxOverrun7); else passCount++;
  endtask

`ifdef UART_RTS_CTS_EN
  task automatic test_flow_control();
    int   waitCycles;
    logic sawPop;
    @(posedge clk);
    #2;
    cts8 = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    txData8  = 32'h0000003C;
    txEmpty8 = 1'b0;
    sawPop   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (txRden8 === 1'b1) sawPop = 1'b1;
      @(posedge clk);
      #1;
    end
    checkCount++; if (sawPop !== 1'b0) $display("[TB] FAIL cts_block actual=popped expected=no pop"); else passCount++;
    cts8 = 1'b0;
    waitCycles = 0;
    while (txRden8 !== 1'b1 && waitCycles < 4) begin
      @(posedge clk);
      #1;
      waitCycles++;
    end
    checkCount++; if (waitCycles > 3) $display("[TB] FAIL cts_release actual=%0d clk expected<=3", waitCycles); else passCount++;
    @(posedge clk);
    #1;
    txEmpty8 = 1'b1;
    waitCycles = 0;
    while (txBusy8 === 1'b1 && waitCycles < 300) begin
      @(posedge clk);
      #1;
      waitCycles++;
    end
    @(posedge clk);
    #2;
    rxFull7 = 1'b1;
    @(posedge clk);
    #1;
    checkCount++; if (rts7 !== 1'b1) $display("[TB] FAIL rts_set actual=%b expected=1", rts7); else passCount++;
    rxFull7 = 1'b0;
    @(posedge clk);
    #1;
    checkCount++; if (rts7 !== 1'b0) $display("[TB] FAIL rts_clear actual=%b expected=0", rts7); else passCount++;
  endtask
`endif

  task automatic test_reset_mid_tx();
    int waitCycles;
    @(posedge clk);
    #2;
    txData8  = 32'h00000000;
    txEmpty8 = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    checkCount++; if (tx8 !== 1'b0) $display("[TB] FAIL mid_tx_low actual=%b expected=0", tx8); else passCount++;
    #1;
    rst = 1'b1;
    #1;
    checkCount++; if (tx8 !== 1'b1) $display("[TB] FAIL mid_rst_tx actual=%b expected=1", tx8); else passCount++;
    checkCount++; if (txBusy8 !== 1'b0) $display("[TB] FAIL mid_rst_busy actual=%b expected=0", txBusy8); else passCount++;
    checkCount++; if (txRden8 !== 1'b0) $display("[TB] FAIL mid_rst_rden actual=%b expected=0", txRden8); else passCount++;
    checkCount++; if (rxOverrun7 !== 1'b0) $display("[TB] FAIL mid_rst_overrun actual=%b expected=0", rxOverrun7); else passCount++;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkCount++; if (txRden8 !== 1'b1) $display("[TB] FAIL restart_pop actual=%b expected=1", txRden8); else passCount++;
    @(posedge clk);
    #1;
    txEmpty8 = 1'b1;
    checkCount++; if (tx8 !== 1'b0) $display("[TB] FAIL restart_start actual=%b expected=0", tx8); else passCount++;
    checkCount++; if (txBusy8 !== 1'b1) $display("[TB] FAIL restart_busy actual=%b expected=1", txBusy8); else passCount++;
    waitCycles = 0;
    while (txBusy8 === 1'b1 && waitCycles < 300) begin
      @(posedge clk);
      #1;
      waitCycles++;
    end
    checkCount++; if (waitCycles !== 160) $display("[TB] FAIL restart_len actual=%0d expected=160", waitCycles); else passCount++;
  endtask

  initial begin
    test_reset();
    test_tx_8n1();
    test_rx_frames();
    test_glitch();
    test_overrun();
`ifdef UART_RTS_CTS_EN
    test_flow_control();
`endif
    test_reset_mid_tx();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
